// File: rtl/axil_regbank_pkg.sv
// Shared response codes, STATUS bit positions and the byte-merge helper for the
// AXI4-Lite register bank. STATUS exists only when AXIL_REGBANK_IRQ_EN is defined.
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STATUS_DONE_BIT  = 0;
    localparam int STATUS_IRQEN_BIT = 1;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_wr_collect.sv
// Pairs independently arriving AW and W beats into a single-cycle write strobe
// and owns the B channel. Build option AXIL_REGBANK_IRQ_EN does not affect this file.
module axil_wr_collect
    import axil_regbank_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_strb_o,
    input  logic              wr_err_i
);

    logic              aw_lat_q, aw_lat_d;
    logic              w_lat_q, w_lat_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic              aw_hs, w_hs;

    // A beat arriving this cycle bypasses its latch so a same-cycle pair executes directly.
    always_comb begin
        s_axi_awready = aresetn & ~aw_lat_q & ~bvalid_q;
        s_axi_wready  = aresetn & ~w_lat_q & ~bvalid_q;
        aw_hs         = s_axi_awvalid & s_axi_awready;
        w_hs          = s_axi_wvalid & s_axi_wready;
        wr_en_o       = (aw_lat_q | aw_hs) & (w_lat_q | w_hs);
        wr_addr_o     = aw_lat_q ? aw_addr_q : s_axi_awaddr;
        wr_data_o     = w_lat_q ? w_data_q : s_axi_wdata;
        wr_strb_o     = w_lat_q ? w_strb_q : s_axi_wstrb;
    end

    always_comb begin
        aw_lat_d  = aw_lat_q;
        w_lat_d   = w_lat_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (aw_hs) begin
            aw_lat_d  = 1'b1;
            aw_addr_d = s_axi_awaddr;
        end
        if (w_hs) begin
            w_lat_d  = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
            bresp_d  = RESP_OKAY;
        end
        if (wr_en_o) begin
            aw_lat_d = 1'b0;
            w_lat_d  = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = wr_err_i ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            aw_lat_q <= 1'b0;
            w_lat_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            aw_lat_q <= aw_lat_d;
            w_lat_q  <= w_lat_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        aw_addr_q <= aw_addr_d;
        w_data_q  <= w_data_d;
        w_strb_q  <= w_strb_d;
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;

endmodule

// File: rtl/axil_aes_regbank.sv
// AXI4-Lite register bank for the AES core: NUM_RW RW words, NUM_RO RO words and,
// with AXIL_REGBANK_IRQ_EN defined, a STATUS word with sticky done and irq enable.
module axil_aes_regbank
    import axil_regbank_pkg::*;
#(
    parameter int NUM_RW  = 13,
    parameter int NUM_RO  = 4,
    parameter int ADDR_W  = 8,
    parameter int CLR_REG = 0,
    parameter int CLR_BIT = 3
) (
    input  logic                                      clk,
    input  logic                                      aresetn,
    input  logic [ADDR_W-1:0]                         s_axi_awaddr,
    input  logic                                      s_axi_awvalid,
    output logic                                      s_axi_awready,
    input  logic [31:0]                               s_axi_wdata,
    input  logic [3:0]                                s_axi_wstrb,
    input  logic                                      s_axi_wvalid,
    output logic                                      s_axi_wready,
    output logic [1:0]                                s_axi_bresp,
    output logic                                      s_axi_bvalid,
    input  logic                                      s_axi_bready,
    input  logic [ADDR_W-1:0]                         s_axi_araddr,
    input  logic                                      s_axi_arvalid,
    output logic                                      s_axi_arready,
    output logic [31:0]                               s_axi_rdata,
    output logic [1:0]                                s_axi_rresp,
    output logic                                      s_axi_rvalid,
    input  logic                                      s_axi_rready,
    output logic [32*NUM_RW-1:0]                      rw_regs_o,
    input  logic [(NUM_RO > 0 ? 32*NUM_RO : 32)-1:0]  ro_regs_i,
    input  logic                                      done_i,
    output logic                                      irq_o
);

    localparam int STATUS_IDX = NUM_RW + NUM_RO;
`ifdef AXIL_REGBANK_IRQ_EN
    localparam bit STATUS_MAPPED = 1'b1;
`else
    localparam bit STATUS_MAPPED = 1'b0;
`endif

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_err;
    logic [31:0]       wr_idx, rd_idx;
    logic [31:0]       rw_q [NUM_RW];
    logic [31:0]       rw_d [NUM_RW];
    logic              done_q, done_rise;
    logic              done_sticky, irq_en;
    logic [31:0]       status_word;
    logic [31:0]       rd_word;
    logic              rd_err;
    logic              ar_hs;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              unused_addr_bits;

    axil_wr_collect #(.ADDR_W(ADDR_W)) u_wr_collect (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_strb_o    (wr_strb),
        .wr_err_i     (wr_err)
    );

    assign unused_addr_bits = ^{wr_addr[1:0], s_axi_araddr[1:0]};
    assign wr_idx           = 32'(wr_addr[ADDR_W-1:2]);
    assign rd_idx           = 32'(s_axi_araddr[ADDR_W-1:2]);
    assign wr_err           = (wr_idx >= 32'(NUM_RW)) &&
                              !(STATUS_MAPPED && wr_idx == 32'(STATUS_IDX));
    assign done_rise        = done_i & ~done_q;

    // The auto-clear is applied after the write merge so it overrides that one bit.
    always_comb begin
        for (int i = 0; i < NUM_RW; i++) begin
            rw_d[i] = rw_q[i];
            if (wr_en && wr_idx == 32'(i)) begin
                rw_d[i] = apply_wstrb(rw_q[i], wr_data, wr_strb);
            end
        end
        if (done_rise) begin
            rw_d[CLR_REG][CLR_BIT] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
            done_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) rw_q[i] <= rw_d[i];
            done_q <= done_i;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RW; i++) begin
            rw_regs_o[32*i +: 32] = rw_q[i];
        end
    end

`ifdef AXIL_REGBANK_IRQ_EN
    logic sticky_q, sticky_d;
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    // A done edge in the same cycle as a W1C keeps the sticky bit set.
    always_comb begin
        sticky_d = sticky_q;
        irq_en_d = irq_en_q;
        if (wr_en && wr_idx == 32'(STATUS_IDX) && wr_strb[0]) begin
            irq_en_d = wr_data[STATUS_IRQEN_BIT];
            if (wr_data[STATUS_DONE_BIT]) sticky_d = 1'b0;
        end
        if (done_rise) sticky_d = 1'b1;
        irq_d = sticky_q & irq_en_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sticky_q <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign done_sticky = sticky_q;
    assign irq_en      = irq_en_q;
    assign irq_o       = irq_q;
`else
    assign done_sticky = 1'b0;
    assign irq_en      = 1'b0;
    assign irq_o       = 1'b0;
`endif

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_DONE_BIT]  = done_sticky;
        status_word[STATUS_IRQEN_BIT] = irq_en;
    end

    // Read data comes from current register state, so a same-cycle write is not visible.
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b1;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rd_idx == 32'(i)) begin
                rd_word = rw_q[i];
                rd_err  = 1'b0;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (rd_idx == 32'(NUM_RW + j)) begin
                rd_word = ro_regs_i[32*j +: 32];
                rd_err  = 1'b0;
            end
        end
        if (STATUS_MAPPED && rd_idx == 32'(STATUS_IDX)) begin
            rd_word = status_word;
            rd_err  = 1'b0;
        end
    end

    always_comb begin
        s_axi_arready = aresetn & ~rvalid_q;
        ar_hs         = s_axi_arvalid & s_axi_arready;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axil_aes_regbank.sv
// Randomised self-checking bench for axil_aes_regbank against an array-based register
// model; the STATUS/IRQ checks follow AXIL_REGBANK_IRQ_EN.
module tb_axil_aes_regbank;

    localparam int NUM_RW     = 13;
    localparam int NUM_RO     = 4;
    localparam int ADDR_W     = 8;
    localparam int CLR_REG    = 0;
    localparam int CLR_BIT    = 3;
    localparam int STATUS_IDX = NUM_RW + NUM_RO;
`ifdef AXIL_REGBANK_IRQ_EN
    localparam bit HAS_STATUS = 1'b1;
`else
    localparam bit HAS_STATUS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   aresetn = 1'b0;
    logic [ADDR_W-1:0]      s_axi_awaddr = '0;
    logic                   s_axi_awvalid = 1'b0;
    logic                   s_axi_awready;
    logic [31:0]            s_axi_wdata = '0;
    logic [3:0]             s_axi_wstrb = '0;
    logic                   s_axi_wvalid = 1'b0;
    logic                   s_axi_wready;
    logic [1:0]             s_axi_bresp;
    logic                   s_axi_bvalid;
    logic                   s_axi_bready = 1'b0;
    logic [ADDR_W-1:0]      s_axi_araddr = '0;
    logic                   s_axi_arvalid = 1'b0;
    logic                   s_axi_arready;
    logic [31:0]            s_axi_rdata;
    logic [1:0]             s_axi_rresp;
    logic                   s_axi_rvalid;
    logic                   s_axi_rready = 1'b0;
    logic [32*NUM_RW-1:0]   rw_regs_o;
    logic [32*NUM_RO-1:0]   ro_regs_i = '0;
    logic                   done_i = 1'b0;
    logic                   irq_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rw [NUM_RW];
    logic        m_irq_en = 1'b0;
    logic        m_sticky = 1'b0;

    axil_aes_regbank #(
        .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .ADDR_W(ADDR_W),
        .CLR_REG(CLR_REG), .CLR_BIT(CLR_BIT)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .rw_regs_o(rw_regs_o), .ro_regs_i(ro_regs_i), .done_i(done_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8*b));
        return (o & ~m) | (d & m);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int idx);
        return ADDR_W'(idx * 4 + int'($urandom_range(0, 3)));
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        if (idx < NUM_RW) begin
            m_rw[idx] = merge(m_rw[idx], d, s);
            resp = 2'b00;
        end else if (HAS_STATUS && idx == STATUS_IDX) begin
            if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) m_sticky = 1'b0;
            end
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] resp);
        d = '0;
        resp = 2'b00;
        if (idx < NUM_RW) d = m_rw[idx];
        else if (idx < NUM_RW + NUM_RO) d = ro_regs_i[32*(idx-NUM_RW) +: 32];
        else if (HAS_STATUS && idx == STATUS_IDX) d = {30'd0, m_irq_en, m_sticky};
        else resp = 2'b10;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_RW; i++) m_rw[i] = '0;
        m_irq_en = 1'b0;
        m_sticky = 1'b0;
    endtask

    task automatic finish_b(output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_axi_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_axi_bvalid) begin
            check("b_timeout", 32'(s_axi_bvalid), 32'd1);
            resp = 2'b11;
        end else begin
            resp = s_axi_bresp;
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_ok, w_ok, fa, fw;
        int n;
        aw_ok = 0; w_ok = 0; n = 0;
        @(posedge clk); #1;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            @(negedge clk);
            fa = s_axi_awvalid && s_axi_awready;
            fw = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (fa) begin aw_ok = 1; s_axi_awvalid = 1'b0; end
            if (fw) begin w_ok = 1; s_axi_wvalid = 1'b0; end
            n++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        if (!(aw_ok && w_ok)) check("wr_hs_timeout", 32'(aw_ok && w_ok), 32'd1);
        finish_b(resp);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        bit fr;
        int n;
        fr = 0; n = 0;
        @(posedge clk); #1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        while (!fr && n < 20) begin
            @(negedge clk);
            fr = s_axi_arready;
            @(posedge clk); #1;
            n++;
        end
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        if (!s_axi_rvalid) begin
            check("r_timeout", 32'(s_axi_rvalid), 32'd1);
            d = 'x; resp = 2'b11;
        end else begin
            d = s_axi_rdata; resp = s_axi_rresp;
        end
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        m_rw[CLR_REG][CLR_BIT] = 1'b0;
        if (HAS_STATUS) m_sticky = 1'b1;
    endtask

    initial begin
        logic [1:0]  resp, eresp;
        logic [31:0] d, ed, old5;
        int          idx;
        logic [3:0]  s;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
        check("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid, irq_o}), 32'd0);
        check("rst_resp_data", {s_axi_rdata[29:0], s_axi_bresp}, 32'd0);
        check("rst_rresp", 32'(s_axi_rresp), 32'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;

        for (int i = 0; i < NUM_RW; i++) begin
            axi_read(addr_of(i), d, resp);
            check("rst_rw_read", d, 32'd0);
        end
        axi_write(addr_of(0), 32'h0000000F, 4'hF, resp);
        model_write(0, 32'h0000000F, 4'hF, eresp);
        check("first_bresp", 32'(resp), 32'(eresp));
        check("first_rw_o", rw_regs_o[31:0], 32'h0000000F);

        // Randomised traffic across RW, RO, STATUS and unmapped words.
        for (int it = 0; it < 80; it++) begin
            for (int j = 0; j < NUM_RO; j++) ro_regs_i[32*j +: 32] = $urandom;
            idx = int'($urandom_range(0, NUM_RW + NUM_RO + 2));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(addr_of(idx), d, s, resp);
                model_write(idx, d, s, eresp);
                check("rnd_bresp", 32'(resp), 32'(eresp));
                if (idx < NUM_RW) check("rnd_rw_o", rw_regs_o[32*idx +: 32], m_rw[idx]);
            end else begin
                axi_read(addr_of(idx), d, resp);
                model_read(idx, ed, eresp);
                check("rnd_rdata", d, ed);
                check("rnd_rresp", 32'(resp), 32'(eresp));
            end
        end
        for (int i = 0; i < NUM_RW; i++) check("rnd_final_rw_o", rw_regs_o[32*i +: 32], m_rw[i]);

        // W arrives three cycles ahead of AW.
        axi_write(addr_of(2), 32'h11223344, 4'hF, resp);
        model_write(2, 32'h11223344, 4'hF, eresp);
        @(posedge clk); #1;
        s_axi_wdata = 32'hAABBCCDD; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("wfirst_wready", 32'(s_axi_wready), 32'd1);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s_axi_awaddr = addr_of(2); s_axi_awvalid = 1'b1;
        @(negedge clk);
        check("wfirst_bvalid_pre", 32'(s_axi_bvalid), 32'd0);
        check("wfirst_awready", 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        check("wfirst_bvalid_edge", 32'(s_axi_bvalid), 32'd1);
        finish_b(resp);
        model_write(2, 32'hAABBCCDD, 4'b0101, eresp);
        check("wfirst_bresp", 32'(resp), 32'(eresp));
        axi_read(addr_of(2), d, resp);
        check("wfirst_readback", d, 32'h11BB33DD);

        // RO write, unmapped read, RO read.
        axi_write(addr_of(NUM_RW), 32'h12345678, 4'hF, resp);
        check("ro_write_bresp", 32'(resp), 32'd2);
        for (int i = 0; i < NUM_RW; i++) check("ro_write_nochange", rw_regs_o[32*i +: 32], m_rw[i]);
        axi_read(addr_of(NUM_RW + NUM_RO + 1), d, resp);
        check("unmapped_rdata", d, 32'd0);
        check("unmapped_rresp", 32'(resp), 32'd2);
        ro_regs_i[31:0] = 32'hCAFEF00D;
        axi_read(addr_of(NUM_RW), d, resp);
        check("ro_rdata", d, 32'hCAFEF00D);
        check("ro_rresp", 32'(resp), 32'd0);

        // Auto-clear alone, then colliding with a write to the same bit.
        axi_write(addr_of(0), 32'h000000FF, 4'hF, resp);
        model_write(0, 32'h000000FF, 4'hF, eresp);
        pulse_done();
        axi_read(addr_of(0), d, resp);
        check("clr_alone", d, m_rw[0]);
        check("clr_alone_abs", d, 32'h000000F7);
        axi_write(addr_of(0), 32'h00000008, 4'hF, resp);
        model_write(0, 32'h00000008, 4'hF, eresp);
        @(posedge clk); #1;
        s_axi_awaddr = addr_of(0); s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0000000B; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        done_i = 1'b1;
        @(negedge clk);
        check("clr_coll_ready", 32'({s_axi_awready, s_axi_wready}), 32'd3);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; done_i = 1'b0;
        finish_b(resp);
        model_write(0, 32'h0000000B, 4'hF, eresp);
        m_rw[CLR_REG][CLR_BIT] = 1'b0;
        if (HAS_STATUS) m_sticky = 1'b1;
        check("clr_coll_bresp", 32'(resp), 32'd0);
        axi_read(addr_of(0), d, resp);
        check("clr_coll_read", d, 32'h00000003);

        // STATUS and interrupt.
        axi_write(addr_of(STATUS_IDX), 32'h00000001, 4'h1, resp);
        model_write(STATUS_IDX, 32'h00000001, 4'h1, eresp);
        check("st_clr_bresp", 32'(resp), 32'(eresp));
        axi_write(addr_of(STATUS_IDX), 32'h00000002, 4'h1, resp);
        model_write(STATUS_IDX, 32'h00000002, 4'h1, eresp);
        check("st_en_bresp", 32'(resp), 32'(eresp));
        repeat (2) @(posedge clk);
        #1;
        check("irq_idle", 32'(irq_o), 32'd0);
        pulse_done();
        check("irq_not_yet", 32'(irq_o), 32'd0);
        @(posedge clk); #1;
        check("irq_after_sticky", 32'(irq_o), HAS_STATUS ? 32'd1 : 32'd0);
        axi_read(addr_of(STATUS_IDX), d, resp);
        model_read(STATUS_IDX, ed, eresp);
        check("st_read_set", d, ed);
        check("st_read_rresp", 32'(resp), HAS_STATUS ? 32'd0 : 32'd2);
        axi_write(addr_of(STATUS_IDX), 32'h00000003, 4'h1, resp);
        model_write(STATUS_IDX, 32'h00000003, 4'h1, eresp);
        check("st_w1c_bresp", 32'(resp), HAS_STATUS ? 32'd0 : 32'd2);
        check("irq_after_w1c", 32'(irq_o), 32'd0);
        axi_read(addr_of(STATUS_IDX), d, resp);
        model_read(STATUS_IDX, ed, eresp);
        check("st_read_clr", d, ed);

        // Backpressure with a simultaneous read and write to the same word.
        old5 = m_rw[5];
        @(posedge clk); #1;
        s_axi_awaddr = addr_of(5); s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h5A5AA5A5; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = addr_of(5); s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("bp_ready_idle", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        model_write(5, 32'h5A5AA5A5, 4'hF, eresp);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd3);
            check("bp_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
            check("bp_rdata_old", s_axi_rdata, old5);
            check("bp_bresp", 32'(s_axi_bresp), 32'd0);
        end
        s_axi_rready = 1'b1;
        finish_b(resp);
        s_axi_rready = 1'b0;
        @(negedge clk);
        check("bp_released", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
        check("bp_rw_o_new", rw_regs_o[32*5 +: 32], m_rw[5]);

        // Reset while an AW is latched.
        @(posedge clk); #1;
        s_axi_awaddr = addr_of(3); s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("mid_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
        check("mid_rst_rw_o", rw_regs_o[31:0], 32'd0);
        model_reset();
        @(posedge clk); #1;
        aresetn = 1'b1;
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("mid_rst_no_b", 32'(s_axi_bvalid), 32'd0);
        end
        @(posedge clk); #1;
        s_axi_awaddr = addr_of(3); s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        finish_b(resp);
        model_write(3, 32'hDEADBEEF, 4'hF, eresp);
        check("mid_rst_bresp", 32'(resp), 32'(eresp));
        axi_read(addr_of(3), d, resp);
        check("mid_rst_readback", d, m_rw[3]);
        for (int i = 0; i < NUM_RW; i++) check("end_rw_o", rw_regs_o[32*i +: 32], m_rw[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
